// File: rtl/vram_responder_pkg.sv
// Shared constants for the PPU VRAM responder: pad direction encodings,
// FSM state codes and the bit layout of the synchronised pin bundle.
// Pure declarations, no logic.
package vram_responder_pkg;

    // Pad direction encodings.
    localparam logic DIR_INPUT      = 1'b0;
    localparam logic DIR_OUTPUT     = 1'b1;
    localparam logic LVL_DIR_INPUT  = 1'b0;
    localparam logic LVL_DIR_OUTPUT = 1'b1;

    // FSM state codes.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_A  = 3'd1;
    localparam logic [2:0] ST_RD_B  = 3'd2;
    localparam logic [2:0] ST_DRIVE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_WR_A  = 3'd5;
    localparam logic [2:0] ST_WR_B  = 3'd6;

    // Layout of the synchronised pin bundle:
    // {vrd_n, vawr_n, vbwr_n, va14, vaa[13:0], vab[13:0], vda[7:0], vdb[7:0]}
    localparam int PIN_W    = 48;
    localparam int P_VRD    = 47;
    localparam int P_VAWR   = 46;
    localparam int P_VBWR   = 45;
    localparam int P_VA14   = 44;
    localparam int P_VAA_HI = 43;
    localparam int P_VAA_LO = 30;
    localparam int P_VAB_HI = 29;
    localparam int P_VAB_LO = 16;
    localparam int P_VDA_HI = 15;
    localparam int P_VDA_LO = 8;
    localparam int P_VDB_HI = 7;
    localparam int P_VDB_LO = 0;

    // Strobes reset to their idle (high) level so reset release cannot fake an edge.
    localparam logic [PIN_W-1:0] PIN_RST = {3'b111, 45'd0};

    // True while a read lookup is in flight.
    function automatic logic is_lookup(input logic [2:0] st);
        return (st == ST_RD_A) || (st == ST_RD_B);
    endfunction

endpackage

// File: rtl/vram_responder_pin_sync.sv
// N-stage synchroniser for a bundle of async pins, plus one extra flop of history.
// Latency: STAGES clk to cur, STAGES+1 clk to prev.
// No backpressure; samples every clk.
module vram_responder_pin_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] prev
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift chain; prev holds the sample before cur for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
            prev <= stage[STAGES-1];
        end
    end

    assign cur = stage[STAGES-1];

endmodule

// File: rtl/vram_responder.sv
// Emulates the two 32Kx8 PPU VRAM chips: captures PPU strobes, answers reads on vda/vdb, commits writes via req/ack.
// Latency: vrd_n fall to data driven = SYNC_STAGES + 1 + two memory ack waits + 1 clk.
// Backpressure: one memory request at a time; mem_req held stable until mem_ack; at most one read and one write per chip queued.
module vram_responder
    import vram_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DRIVE_HOLD  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vrd_n_in,
    input  logic        vawr_n_in,
    input  logic        vbwr_n_in,
    input  logic        va14_in,
    input  logic [13:0] vaa_in,
    input  logic [13:0] vab_in,
    input  logic [7:0]  vda_in,
    input  logic [7:0]  vdb_in,
    output logic        vrd_n_out,
    output logic        vawr_n_out,
    output logic        vbwr_n_out,
    output logic        vrd_n_dir,
    output logic        vawr_n_dir,
    output logic        vbwr_n_dir,
    output logic        va14_out,
    output logic [13:0] vaa_out,
    output logic [13:0] vab_out,
    output logic        va14_dir,
    output logic        vaa_dir,
    output logic        vab_dir,
    output logic        lvl_va_dir,
    output logic        lvl_vd_dir,
    output logic [7:0]  vda_out,
    output logic [7:0]  vdb_out,
    output logic        vda_dir,
    output logic        vdb_dir,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        err_late
);

    localparam int HOLD_W = (DRIVE_HOLD > 1) ? $clog2(DRIVE_HOLD) : 1;

    // The PPU owns every strobe and address pin; we never drive them.
    assign vrd_n_out  = 1'b1;
    assign vawr_n_out = 1'b1;
    assign vbwr_n_out = 1'b1;
    assign vrd_n_dir  = DIR_INPUT;
    assign vawr_n_dir = DIR_INPUT;
    assign vbwr_n_dir = DIR_INPUT;
    assign va14_out   = 1'b0;
    assign vaa_out    = '0;
    assign vab_out    = '0;
    assign va14_dir   = DIR_INPUT;
    assign vaa_dir    = DIR_INPUT;
    assign vab_dir    = DIR_INPUT;
    assign lvl_va_dir = LVL_DIR_INPUT;

    logic [PIN_W-1:0] pin_raw, pin_cur, pin_prev;
    logic             unused_pins;

    assign pin_raw = {vrd_n_in, vawr_n_in, vbwr_n_in, va14_in, vaa_in, vab_in, vda_in, vdb_in};
    // Write data is taken from the older sample, so the current data bits go unread.
    assign unused_pins = ^pin_cur[P_VDA_HI:P_VDB_LO];

    vram_responder_pin_sync #(
        .WIDTH   (PIN_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (PIN_RST)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pin_raw),
        .cur  (pin_cur),
        .prev (pin_prev)
    );

    logic rd_fall, rd_rise, wa_rise, wb_rise;
    assign rd_fall =  pin_prev[P_VRD]  & ~pin_cur[P_VRD];
    assign rd_rise = ~pin_prev[P_VRD]  &  pin_cur[P_VRD];
    assign wa_rise = ~pin_prev[P_VAWR] &  pin_cur[P_VAWR];
    assign wb_rise = ~pin_prev[P_VBWR] &  pin_cur[P_VBWR];

    logic [14:0] wa_addr, wb_addr, rd_addr_a, rd_addr_b;
    logic [7:0]  wa_data, wb_data;

    // Latch write address/data from the last strobe-low sample and read addresses at the fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wa_addr   <= '0;
            wa_data   <= '0;
            wb_addr   <= '0;
            wb_data   <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
        end else begin
            if (wa_rise) begin
                wa_addr <= {pin_prev[P_VA14], pin_prev[P_VAA_HI:P_VAA_LO]};
                wa_data <= pin_prev[P_VDA_HI:P_VDA_LO];
            end
            if (wb_rise) begin
                wb_addr <= {pin_prev[P_VA14], pin_prev[P_VAB_HI:P_VAB_LO]};
                wb_data <= pin_prev[P_VDB_HI:P_VDB_LO];
            end
            if (rd_fall) begin
                rd_addr_a <= {pin_cur[P_VA14], pin_cur[P_VAA_HI:P_VAA_LO]};
                rd_addr_b <= {pin_cur[P_VA14], pin_cur[P_VAB_HI:P_VAB_LO]};
            end
        end
    end

    logic [2:0]        state;
    logic              pend_a, pend_b, rd_pend;
    logic              rd_rose;   // current/queued read's strobe already ended
    logic [HOLD_W-1:0] hold_cnt;
    logic              late_now;
    logic              driving;

    assign late_now = rd_rose | rd_rise;
    assign driving  = (state == ST_DRIVE) || (state == ST_HOLD);

    assign vda_dir    = driving ? DIR_OUTPUT : DIR_INPUT;
    assign vdb_dir    = driving ? DIR_OUTPUT : DIR_INPUT;
    assign lvl_vd_dir = driving ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;

    // Sequencer: pending flags, memory handshake, read data capture and drive window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend_a    <= 1'b0;
            pend_b    <= 1'b0;
            rd_pend   <= 1'b0;
            rd_rose   <= 1'b0;
            err_late  <= 1'b0;
            hold_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vda_out   <= '0;
            vdb_out   <= '0;
        end else begin
            // A new read strobe starts fresh; a rise before lookups finish marks it late.
            if (rd_fall) rd_rose <= 1'b0;
            if (rd_rise && (rd_pend || is_lookup(state))) begin
                rd_rose  <= 1'b1;
                err_late <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rd_pend) begin
                        rd_pend  <= 1'b0;
                        state    <= ST_RD_A;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_sel  <= 1'b0;
                        mem_addr <= rd_addr_a;
                    end else if (pend_a) begin
                        pend_a    <= 1'b0;
                        state     <= ST_WR_A;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_sel   <= 1'b0;
                        mem_addr  <= wa_addr;
                        mem_wdata <= wa_data;
                    end else if (pend_b) begin
                        pend_b    <= 1'b0;
                        state     <= ST_WR_B;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_sel   <= 1'b1;
                        mem_addr  <= wb_addr;
                        mem_wdata <= wb_data;
                    end
                end
                ST_RD_A: begin
                    if (mem_req && mem_ack) begin
                        mem_req <= 1'b0;
                        vda_out <= mem_rdata;
                        state   <= late_now ? ST_IDLE : ST_RD_B;
                    end
                end
                ST_RD_B: begin
                    // First cycle here has mem_req low: issue chip B unless the strobe already ended.
                    if (!mem_req) begin
                        if (late_now) begin
                            state <= ST_IDLE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_sel  <= 1'b1;
                            mem_addr <= rd_addr_b;
                        end
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        vdb_out <= mem_rdata;
                        state   <= late_now ? ST_IDLE : ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (rd_rise) begin
                        hold_cnt <= HOLD_W'(DRIVE_HOLD - 1);
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) state <= ST_IDLE;
                    else                hold_cnt <= hold_cnt - 1'b1;
                end
                ST_WR_A, ST_WR_B: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // New edges win over the IDLE consumption above.
            if (rd_fall) rd_pend <= 1'b1;
            if (wa_rise) pend_a  <= 1'b1;
            if (wb_rise) pend_b  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_responder.sv
// Bench for vram_responder: the backing memory is modelled as two 32K byte arrays
// answered by a req/ack responder; PPU cycles are driven on the pins and results
// are checked against the arrays and hand-computed expectations.
module tb_vram_responder;
    import vram_responder_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int DRIVE_HOLD  = 2;

    logic        clk, rst;
    logic        vrd_n_in, vawr_n_in, vbwr_n_in, va14_in;
    logic [13:0] vaa_in, vab_in;
    logic [7:0]  vda_in, vdb_in;
    logic        vrd_n_out, vawr_n_out, vbwr_n_out, vrd_n_dir, vawr_n_dir, vbwr_n_dir;
    logic        va14_out, va14_dir, vaa_dir, vab_dir, lvl_va_dir, lvl_vd_dir;
    logic [13:0] vaa_out, vab_out;
    logic [7:0]  vda_out, vdb_out;
    logic        vda_dir, vdb_dir;
    logic        mem_req, mem_we, mem_sel, mem_ack, err_late;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    vram_responder #(.SYNC_STAGES(SYNC_STAGES), .DRIVE_HOLD(DRIVE_HOLD)) dut (
        .clk(clk), .rst(rst),
        .vrd_n_in(vrd_n_in), .vawr_n_in(vawr_n_in), .vbwr_n_in(vbwr_n_in), .va14_in(va14_in),
        .vaa_in(vaa_in), .vab_in(vab_in), .vda_in(vda_in), .vdb_in(vdb_in),
        .vrd_n_out(vrd_n_out), .vawr_n_out(vawr_n_out), .vbwr_n_out(vbwr_n_out),
        .vrd_n_dir(vrd_n_dir), .vawr_n_dir(vawr_n_dir), .vbwr_n_dir(vbwr_n_dir),
        .va14_out(va14_out), .vaa_out(vaa_out), .vab_out(vab_out),
        .va14_dir(va14_dir), .vaa_dir(vaa_dir), .vab_dir(vab_dir),
        .lvl_va_dir(lvl_va_dir), .lvl_vd_dir(lvl_vd_dir),
        .vda_out(vda_out), .vdb_out(vdb_out), .vda_dir(vda_dir), .vdb_dir(vdb_dir),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_late(err_late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic        sel;
        logic [14:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    logic [7:0] vram_a [32768];
    logic [7:0] vram_b [32768];
    txn_t       txq[$];
    int         ack_delay = 2;
    int         proto_err = 0;
    int         dir_err = 0;
    int         drive_cycles = 0;
    int         req_in_drive = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    // Backing memory: acks each request ack_delay clk after it appears, checks handshake rules.
    initial begin : mem_model
        bit   busy;
        bit   just_acked;
        int   cnt;
        txn_t cur;
        busy = 0; just_acked = 0; cnt = 0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (rst) begin
                busy = 0; just_acked = 0;
                continue;
            end
            if (just_acked && mem_req) proto_err++;
            just_acked = 0;
            if (busy) begin
                if (!mem_req || mem_we !== cur.we || mem_sel !== cur.sel ||
                    mem_addr !== cur.addr || (cur.we && mem_wdata !== cur.wdata)) proto_err++;
            end else if (mem_req) begin
                busy = 1; cnt = ack_delay;
                cur = '{we: mem_we, sel: mem_sel, addr: mem_addr, wdata: mem_wdata};
            end
            if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    if (cur.we) begin
                        if (cur.sel) vram_b[cur.addr] = cur.wdata;
                        else         vram_a[cur.addr] = cur.wdata;
                    end else begin
                        mem_rdata = cur.sel ? vram_b[cur.addr] : vram_a[cur.addr];
                    end
                    txq.push_back(cur);
                    mem_ack = 1'b1;
                    busy = 0; just_acked = 1;
                end
            end
        end
    end

    // Drive-window bookkeeping: all three data dirs must agree; no memory traffic while driving.
    always @(negedge clk) begin
        if (!rst) begin
            if (!(vda_dir == vdb_dir && (vda_dir == DIR_OUTPUT) == (lvl_vd_dir == LVL_DIR_OUTPUT))) dir_err++;
            if (vda_dir == DIR_OUTPUT || vdb_dir == DIR_OUTPUT || lvl_vd_dir == LVL_DIR_OUTPUT) begin
                drive_cycles++;
                if (mem_req) req_in_drive++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- PPU stimulus helpers ----------------
    task automatic ppu_read_start(input logic a14, input logic [13:0] aa, input logic [13:0] ab);
        @(negedge clk);
        va14_in = a14; vaa_in = aa; vab_in = ab;
        vrd_n_in = 1'b0;
    endtask

    task automatic ppu_write(input bit chip_b, input logic [14:0] addr, input logic [7:0] data, input int low);
        @(negedge clk);
        va14_in = addr[14];
        if (chip_b) begin vab_in = addr[13:0]; vdb_in = data; vbwr_n_in = 1'b0; end
        else        begin vaa_in = addr[13:0]; vda_in = data; vawr_n_in = 1'b0; end
        repeat (low) @(negedge clk);
        vawr_n_in = 1'b1; vbwr_n_in = 1'b1;
    endtask

    task automatic wait_drive(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vda_dir == DIR_OUTPUT) begin ok = 1; break; end
        end
    endtask

    // Raise vrd_n and count cycles the data bus stays driven afterwards.
    task automatic ppu_read_end(output int held);
        vrd_n_in = 1'b1;
        held = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vda_dir == DIR_OUTPUT) held++;
            else break;
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if ({mem_we, mem_sel, mem_addr, mem_wdata} !== 25'd0) $display("FAIL reset_mem_fields: got %h want 0", {mem_we, mem_sel, mem_addr, mem_wdata}); else n_pass++;
        n_checks++; if ({vda_out, vdb_out} !== 16'h0000) $display("FAIL reset_vd_out: got %h want 0000", {vda_out, vdb_out}); else n_pass++;
        n_checks++; if ({vda_dir, vdb_dir, lvl_vd_dir} !== {DIR_INPUT, DIR_INPUT, LVL_DIR_INPUT}) $display("FAIL reset_vd_dirs: got %b want input", {vda_dir, vdb_dir, lvl_vd_dir}); else n_pass++;
        n_checks++; if (err_late !== 1'b0) $display("FAIL reset_err_late: got %b want 0", err_late); else n_pass++;
        n_checks++; if ({vrd_n_out, vawr_n_out, vbwr_n_out, va14_out, vaa_out, vab_out} !== {3'b111, 29'd0}) $display("FAIL tieoff_values: got %h want %h", {vrd_n_out, vawr_n_out, vbwr_n_out, va14_out, vaa_out, vab_out}, {3'b111, 29'd0}); else n_pass++;
        n_checks++; if ({vrd_n_dir, vawr_n_dir, vbwr_n_dir, va14_dir, vaa_dir, vab_dir, lvl_va_dir} !== {{6{DIR_INPUT}}, LVL_DIR_INPUT}) $display("FAIL tieoff_dirs: got %b want all input", {vrd_n_dir, vawr_n_dir, vbwr_n_dir, va14_dir, vaa_dir, vab_dir, lvl_va_dir}); else n_pass++;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (txq.size() !== 0) $display("FAIL reset_no_traffic: got %0d txns want 0", txq.size()); else n_pass++;
    endtask

    task automatic test_read_basic();
        int base, held; bit ok;
        vram_a[15'h1234] = 8'h5A; vram_b[15'h1234] = 8'hC3;
        ack_delay = 2; base = txq.size();
        ppu_read_start(1'b0, 14'h1234, 14'h1234);
        wait_drive(ok);
        n_checks++; if (!ok) $display("FAIL read_drive_timeout: got no drive want drive"); else n_pass++;
        n_checks++; if (txq.size() - base !== 2) $display("FAIL read_txn_count: got %0d want 2", txq.size() - base); else n_pass++;
        if (txq.size() - base >= 2) begin
            n_checks++; if (txq[base] !== {1'b0, 1'b0, 15'h1234, txq[base].wdata}) $display("FAIL read_txn_a: got we=%b sel=%b addr=%h want we=0 sel=0 addr=1234", txq[base].we, txq[base].sel, txq[base].addr); else n_pass++;
            n_checks++; if (txq[base+1] !== {1'b0, 1'b1, 15'h1234, txq[base+1].wdata}) $display("FAIL read_txn_b: got we=%b sel=%b addr=%h want we=0 sel=1 addr=1234", txq[base+1].we, txq[base+1].sel, txq[base+1].addr); else n_pass++;
        end
        repeat (5) @(negedge clk);
        n_checks++; if ({vda_out, vdb_out} !== 16'h5AC3) $display("FAIL read_data: got %h want 5ac3", {vda_out, vdb_out}); else n_pass++;
        n_checks++; if ({vdb_dir, lvl_vd_dir} !== {DIR_OUTPUT, LVL_DIR_OUTPUT}) $display("FAIL read_dirs_out: got %b want output", {vdb_dir, lvl_vd_dir}); else n_pass++;
        ppu_read_end(held);
        n_checks++; if (held !== SYNC_STAGES + DRIVE_HOLD) $display("FAIL read_release_cycles: got %0d want %0d", held, SYNC_STAGES + DRIVE_HOLD); else n_pass++;
        n_checks++; if ({vda_out, vdb_out} !== 16'h5AC3) $display("FAIL read_data_kept: got %h want 5ac3", {vda_out, vdb_out}); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_single();
        int base, d0;
        base = txq.size(); d0 = drive_cycles; ack_delay = 3;
        ppu_write(1'b0, 15'h4010, 8'hAB, 6);
        repeat (20) @(negedge clk);
        n_checks++; if (txq.size() - base !== 1) $display("FAIL write_txn_count: got %0d want 1", txq.size() - base); else n_pass++;
        if (txq.size() - base >= 1) begin
            n_checks++; if (txq[base] !== {1'b1, 1'b0, 15'h4010, 8'hAB}) $display("FAIL write_txn: got %h want %h", txq[base], {1'b1, 1'b0, 15'h4010, 8'hAB}); else n_pass++;
        end
        n_checks++; if (vram_a[15'h4010] !== 8'hAB) $display("FAIL write_mem: got %h want ab", vram_a[15'h4010]); else n_pass++;
        n_checks++; if (drive_cycles !== d0) $display("FAIL write_no_drive: got %0d drive cycles want 0", drive_cycles - d0); else n_pass++;
    endtask

    task automatic test_dual_write();
        int base, d0;
        base = txq.size(); d0 = drive_cycles; ack_delay = 2;
        @(negedge clk);
        va14_in = 1'b0; vaa_in = 14'h0123; vab_in = 14'h0456; vda_in = 8'h11; vdb_in = 8'h22;
        vawr_n_in = 1'b0; vbwr_n_in = 1'b0;
        repeat (4) @(negedge clk);
        vawr_n_in = 1'b1; vbwr_n_in = 1'b1;
        repeat (25) @(negedge clk);
        n_checks++; if (txq.size() - base !== 2) $display("FAIL dual_txn_count: got %0d want 2", txq.size() - base); else n_pass++;
        if (txq.size() - base >= 2) begin
            n_checks++; if (txq[base] !== {1'b1, 1'b0, 15'h0123, 8'h11}) $display("FAIL dual_first_a: got %h want %h", txq[base], {1'b1, 1'b0, 15'h0123, 8'h11}); else n_pass++;
            n_checks++; if (txq[base+1] !== {1'b1, 1'b1, 15'h0456, 8'h22}) $display("FAIL dual_second_b: got %h want %h", txq[base+1], {1'b1, 1'b1, 15'h0456, 8'h22}); else n_pass++;
        end
        n_checks++; if (drive_cycles !== d0) $display("FAIL dual_no_drive: got %0d drive cycles want 0", drive_cycles - d0); else n_pass++;
    endtask

    task automatic test_late();
        int base, d0, held; bit ok;
        base = txq.size(); d0 = drive_cycles; ack_delay = 10;
        ppu_read_start(1'b0, 14'h0200, 14'h0201);
        repeat (3) @(negedge clk);
        vrd_n_in = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++; if (err_late !== 1'b1) $display("FAIL late_err: got %b want 1", err_late); else n_pass++;
        n_checks++; if (drive_cycles !== d0) $display("FAIL late_no_drive: got %0d drive cycles want 0", drive_cycles - d0); else n_pass++;
        n_checks++; if (txq.size() - base !== 1) $display("FAIL late_lookups: got %0d want 1", txq.size() - base); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL late_idle: got mem_req %b want 0", mem_req); else n_pass++;
        // Following read behaves normally.
        vram_a[15'h0300] = 8'h3E; vram_b[15'h0301] = 8'hE3; ack_delay = 2;
        ppu_read_start(1'b0, 14'h0300, 14'h0301);
        wait_drive(ok);
        repeat (2) @(negedge clk);
        n_checks++; if (!ok || {vda_out, vdb_out} !== 16'h3EE3) $display("FAIL late_next_read: got ok=%b data=%h want ok=1 data=3ee3", ok, {vda_out, vdb_out}); else n_pass++;
        ppu_read_end(held);
        n_checks++; if (err_late !== 1'b1) $display("FAIL late_sticky: got %b want 1", err_late); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_during_drive();
        int base, rq0, held; bit ok;
        vram_a[15'h2345] = 8'h77; vram_b[15'h2345] = 8'h88; ack_delay = 2;
        ppu_read_start(1'b0, 14'h2345, 14'h2345);
        wait_drive(ok);
        base = txq.size(); rq0 = req_in_drive;
        ppu_write(1'b0, 15'h0042, 8'h5D, 3);
        repeat (6) @(negedge clk);
        n_checks++; if (!ok || vda_dir !== DIR_OUTPUT) $display("FAIL wdrv_still_driving: got ok=%b dir=%b want driving", ok, vda_dir); else n_pass++;
        n_checks++; if (txq.size() !== base) $display("FAIL wdrv_deferred: got %0d txns want 0", txq.size() - base); else n_pass++;
        ppu_read_end(held);
        n_checks++; if (txq.size() !== base) $display("FAIL wdrv_after_hold: got %0d txns before release want 0", txq.size() - base); else n_pass++;
        repeat (12) @(negedge clk);
        n_checks++; if (txq.size() - base !== 1 || txq[txq.size()-1] !== {1'b1, 1'b0, 15'h0042, 8'h5D}) $display("FAIL wdrv_write: got %0d txns last=%h want 1 txn %h", txq.size() - base, txq[txq.size()-1], {1'b1, 1'b0, 15'h0042, 8'h5D}); else n_pass++;
        n_checks++; if ({vda_out, vdb_out} !== 16'h7788) $display("FAIL wdrv_read_data: got %h want 7788", {vda_out, vdb_out}); else n_pass++;
        n_checks++; if (req_in_drive !== rq0) $display("FAIL wdrv_req_in_drive: got %0d want 0", req_in_drive - rq0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base, held; bit ok, seen;
        vram_a[15'h0777] = 8'h3C; vram_b[15'h0777] = 8'h96; ack_delay = 6;
        ppu_read_start(1'b0, 14'h0777, 14'h0777);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && mem_sel) begin seen = 1; break; end
        end
        n_checks++; if (!seen) $display("FAIL rstmid_reach_rd_b: got no chip-B request want one"); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if ({vda_dir, vdb_dir, lvl_vd_dir} !== {DIR_INPUT, DIR_INPUT, LVL_DIR_INPUT}) $display("FAIL rstmid_dirs: got %b want input", {vda_dir, vdb_dir, lvl_vd_dir}); else n_pass++;
        n_checks++; if (err_late !== 1'b0) $display("FAIL rstmid_err_late: got %b want 0", err_late); else n_pass++;
        rst = 1'b0;
        base = txq.size(); ack_delay = 2;
        wait_drive(ok);
        repeat (2) @(negedge clk);
        n_checks++; if (!ok || {vda_out, vdb_out} !== 16'h3C96) $display("FAIL rstmid_restart: got ok=%b data=%h want ok=1 data=3c96", ok, {vda_out, vdb_out}); else n_pass++;
        n_checks++; if (txq.size() - base !== 2) $display("FAIL rstmid_txns: got %0d want 2", txq.size() - base); else n_pass++;
        ppu_read_end(held);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            bit          chip_b, ok;
            logic [14:0] addr;
            logic [13:0] other;
            logic [7:0]  data, exp_a, exp_b;
            int          held;
            ack_delay = $urandom_range(1, 4);
            chip_b = 1'($urandom_range(0, 1));
            addr   = 15'($urandom);
            data   = 8'($urandom);
            other  = 14'($urandom);
            ppu_write(chip_b, addr, data, $urandom_range(2, 6));
            repeat (16) @(negedge clk);
            n_checks++; if ((chip_b ? vram_b[addr] : vram_a[addr]) !== data) $display("FAIL rand_write it=%0d: got %h want %h", it, chip_b ? vram_b[addr] : vram_a[addr], data); else n_pass++;
            // Read back the written byte on its chip; the other chip reads an unrelated location.
            exp_a = chip_b ? vram_a[{addr[14], other}] : data;
            exp_b = chip_b ? data : vram_b[{addr[14], other}];
            ppu_read_start(addr[14], chip_b ? other : addr[13:0], chip_b ? addr[13:0] : other);
            wait_drive(ok);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            n_checks++; if (!ok || {vda_out, vdb_out} !== {exp_a, exp_b}) $display("FAIL rand_read it=%0d: got ok=%b data=%h want %h", it, ok, {vda_out, vdb_out}, {exp_a, exp_b}); else n_pass++;
            ppu_read_end(held);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_protocol();
        n_checks++; if (proto_err !== 0) $display("FAIL handshake_rules: got %0d violations want 0", proto_err); else n_pass++;
        n_checks++; if (dir_err !== 0) $display("FAIL dir_consistency: got %0d violations want 0", dir_err); else n_pass++;
    endtask

    initial begin : main
        rst = 1'b1;
        vrd_n_in = 1'b1; vawr_n_in = 1'b1; vbwr_n_in = 1'b1; va14_in = 1'b0;
        vaa_in = '0; vab_in = '0; vda_in = '0; vdb_in = '0;
        for (int i = 0; i < 32768; i++) begin
            vram_a[i] = 8'($urandom);
            vram_b[i] = 8'($urandom);
        end
        test_reset();
        test_read_basic();
        test_write_single();
        test_dual_write();
        test_late();
        test_write_during_drive();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
